// File: rtl/dvp_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dvp_rx                                                          |
// | Purpose  : DVP receive deserialiser. Registers vsync/href/data once, pairs |
// |            bytes high-first into RGB565 pixels, tracks pixel x/y and frame |
// |            boundaries, and flags malformed lines.                          |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            dvp_vsync, dvp_href, dvp_data[7:0]  - camera-side inputs        |
// |            vsync_o, href_o                      - registered sync outputs  |
// |            data_valid_o, data_o[15:0]           - pixel strobe and value   |
// |            pix_x[X_W-1:0], pix_y[Y_W-1:0]       - position of data_o       |
// |            frame_start, frame_done, line_err    - frame/line status        |
// | Option   : DVP_RX_STATS_EN adds line_cnt, last_line_len and frame_err.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dvp_rx #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_POL = 1,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dvp_vsync,
    input  logic           dvp_href,
    input  logic [7:0]     dvp_data,
    output logic           vsync_o,
    output logic           href_o,
    output logic           data_valid_o,
    output logic [15:0]    data_o,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           frame_start,
    output logic           frame_done,
`ifdef DVP_RX_STATS_EN
    output logic [Y_W-1:0] line_cnt,
    output logic [X_W-1:0] last_line_len,
    output logic           frame_err,
`endif
    output logic           line_err
);

    localparam logic [2:0] c_wait_vs = 3'd0;
    localparam logic [2:0] c_wait_fr = 3'd1;
    localparam logic [2:0] c_idle    = 3'd2;
    localparam logic [2:0] c_hi      = 3'd3;
    localparam logic [2:0] c_lo      = 3'd4;

    localparam logic [X_W-1:0] c_x_last = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] c_y_max  = {Y_W{1'b1}};

    // Input stage (s1). vsync is normalised to active-high here so nothing
    // downstream cares about the camera polarity.
    logic       r_vs1;
    logic       r_href1;
    logic       r_href2;
    logic [7:0] r_data1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs1   <= 1'b0;
            r_href1 <= 1'b0;
            r_href2 <= 1'b0;
            r_data1 <= 8'h00;
        end else begin
            r_vs1   <= (VSYNC_POL != 0) ? dvp_vsync : ~dvp_vsync;
            r_href1 <= dvp_href;
            r_href2 <= r_href1;
            r_data1 <= dvp_data;
        end
    end

    assign vsync_o = r_vs1;
    assign href_o  = r_href2;

    // Frame/line state machine
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_wait_vs;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_wait_vs: if (r_vs1)  w_state_nxt = c_wait_fr;
            c_wait_fr: if (!r_vs1) w_state_nxt = c_idle;
            c_idle:    if (r_vs1)  w_state_nxt = c_wait_fr;
                       else if (r_href1) w_state_nxt = c_lo;
            c_hi:      if (r_vs1)  w_state_nxt = c_wait_fr;
                       else if (r_href1) w_state_nxt = c_lo;
                       else w_state_nxt = c_idle;
            c_lo:      if (r_vs1)  w_state_nxt = c_wait_fr;
                       else if (r_href1) w_state_nxt = c_hi;
                       else w_state_nxt = c_idle;
            default:   w_state_nxt = c_wait_vs;
        endcase
    end

    // Per-cycle actions decoded from state and s1 inputs. vsync has priority
    // over href everywhere, so a line cut by vsync never emits its half pixel.
    logic w_latch_hi;
    logic w_emit;
    logic w_line_end;
    logic w_half;
    logic w_vs_hit;
    logic w_frame_entry;
    logic w_in_line;
    logic w_frame_done;

    always_comb begin
        w_latch_hi    = 1'b0;
        w_emit        = 1'b0;
        w_line_end    = 1'b0;
        w_half        = 1'b0;
        w_vs_hit      = 1'b0;
        w_frame_entry = 1'b0;
        w_in_line     = 1'b0;
        case (r_state)
            c_wait_fr: w_frame_entry = !r_vs1;
            c_idle: begin
                if (r_vs1) w_vs_hit   = 1'b1;
                else       w_latch_hi = r_href1;
            end
            c_hi: begin
                w_in_line = 1'b1;
                if (r_vs1)        w_vs_hit   = 1'b1;
                else if (r_href1) w_latch_hi = 1'b1;
                else              w_line_end = 1'b1;
            end
            c_lo: begin
                w_in_line = 1'b1;
                if (r_vs1)        w_vs_hit = 1'b1;
                else if (r_href1) w_emit   = 1'b1;
                else begin
                    w_line_end = 1'b1;
                    w_half     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A frame only counts as done if something was actually received.
    assign w_frame_done = w_vs_hit && ((pix_y != '0) || w_in_line);

    // Datapath
    logic [7:0] r_hi;
    logic       r_first;   // next emitted pixel is the first of the frame
    logic       r_x_sat;   // pix_x already reached the last column this line

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi         <= 8'h00;
            r_first      <= 1'b0;
            r_x_sat      <= 1'b0;
            data_valid_o <= 1'b0;
            data_o       <= 16'h0000;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
        end else begin
            data_valid_o <= w_emit;
            frame_start  <= w_emit && r_first;
            frame_done   <= w_frame_done;

            if (w_latch_hi) r_hi   <= r_data1;
            if (w_emit)     data_o <= {r_hi, r_data1};

            if (w_frame_entry) r_first <= 1'b1;
            else if (w_emit)   r_first <= 1'b0;

            // pix_x labels the pixel currently on data_o, so it advances the
            // cycle after each strobe and parks on the last column.
            if (w_frame_entry || w_line_end) begin
                pix_x   <= '0;
                r_x_sat <= 1'b0;
            end else if (data_valid_o) begin
                if (pix_x == c_x_last) r_x_sat <= 1'b1;
                else                   pix_x   <= pix_x + X_W'(1);
            end

            if (w_frame_entry)
                pix_y <= '0;
            else if (w_line_end && (pix_y != c_y_max))
                pix_y <= pix_y + Y_W'(1);

            // A fresh error beats the first-pixel clear in the same cycle.
            if (w_half || (w_emit && r_x_sat))
                line_err <= 1'b1;
            else if (w_emit && r_first)
                line_err <= 1'b0;
        end
    end

`ifdef DVP_RX_STATS_EN
    localparam logic [X_W-1:0] c_x_act = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] c_y_act = Y_W'(V_ACTIVE);

    logic [X_W-1:0] r_len;
    logic           r_len_bad;

    // A line aborted by vsync is treated as a malformed line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len         <= '0;
            r_len_bad     <= 1'b0;
            line_cnt      <= '0;
            last_line_len <= '0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= w_frame_done &&
                         ((line_cnt != c_y_act) || r_len_bad || w_in_line);
            if (w_frame_entry) begin
                r_len     <= '0;
                r_len_bad <= 1'b0;
                line_cnt  <= '0;
            end else if (w_line_end) begin
                last_line_len <= r_len;
                r_len         <= '0;
                if (r_len != c_x_act)  r_len_bad <= 1'b1;
                if (line_cnt != c_y_max) line_cnt <= line_cnt + Y_W'(1);
            end else if (w_emit && (r_len != {X_W{1'b1}})) begin
                r_len <= r_len + X_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvp_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dvp_rx                                                       |
// | Purpose  : Directed self-checking bench for dvp_rx. Instance a uses        |
// |            H_ACTIVE=4 with active-high vsync; instance b uses H_ACTIVE=2,  |
// |            V_ACTIVE=2 with active-low vsync.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dvp_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        vs_a, hr_a, vs_b, hr_b;
    logic [7:0]  d_a, d_b;
    logic        a_vso, a_hro, a_dv, a_fs, a_fd, a_le;
    logic        b_vso, b_hro, b_dv, b_fs, b_fd, b_le;
    logic [15:0] a_do, b_do;
    logic [10:0] a_x, b_x;
    logic [9:0]  a_y, b_y;
`ifdef DVP_RX_STATS_EN
    logic [9:0]  a_lc, b_lc;
    logic [10:0] a_lll, b_lll;
    logic        a_fe, b_fe;
    logic        a_ferr_seen, b_ferr_seen;
`endif

    dvp_rx #(.H_ACTIVE(4), .V_ACTIVE(480), .VSYNC_POL(1)) dut_a (
        .clk(clk), .rst(rst),
        .dvp_vsync(vs_a), .dvp_href(hr_a), .dvp_data(d_a),
        .vsync_o(a_vso), .href_o(a_hro), .data_valid_o(a_dv), .data_o(a_do),
        .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs), .frame_done(a_fd),
`ifdef DVP_RX_STATS_EN
        .line_cnt(a_lc), .last_line_len(a_lll), .frame_err(a_fe),
`endif
        .line_err(a_le)
    );

    dvp_rx #(.H_ACTIVE(2), .V_ACTIVE(2), .VSYNC_POL(0)) dut_b (
        .clk(clk), .rst(rst),
        .dvp_vsync(vs_b), .dvp_href(hr_b), .dvp_data(d_b),
        .vsync_o(b_vso), .href_o(b_hro), .data_valid_o(b_dv), .data_o(b_do),
        .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs), .frame_done(b_fd),
`ifdef DVP_RX_STATS_EN
        .line_cnt(b_lc), .last_line_len(b_lll), .frame_err(b_fe),
`endif
        .line_err(b_le)
    );

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [15:0] d;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fs;
        logic        le;
        logic        hr;
        logic [31:0] cyc;
    } pix_t;

    pix_t        qa[$];
    pix_t        qb[$];
    logic [31:0] cyc = 32'd0;
    int          na_done = 0;
    int          nb_done = 0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic pix_t mk(input logic [15:0] d, input logic [10:0] x,
                                input logic [9:0] y, input logic fs,
                                input logic le, input logic hr,
                                input logic [31:0] c);
        pix_t p;
        p.d = d; p.x = x; p.y = y; p.fs = fs; p.le = le; p.hr = hr; p.cyc = c;
        return p;
    endfunction

    always @(negedge clk) begin
        if (a_dv) qa.push_back(mk(a_do, a_x, a_y, a_fs, a_le, a_hro, cyc));
        if (b_dv) qb.push_back(mk(b_do, b_x, b_y, b_fs, b_le, b_hro, cyc));
        if (a_fd) begin
            na_done++;
`ifdef DVP_RX_STATS_EN
            a_ferr_seen = a_fe;
`endif
        end
        if (b_fd) begin
            nb_done++;
`ifdef DVP_RX_STATS_EN
            b_ferr_seen = b_fe;
`endif
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    // sel=0 drives instance a (vsync idle low), sel=1 instance b (idle high).
    task automatic drv(input logic sel, input logic vs, input logic hr,
                       input logic [7:0] d);
        @(negedge clk);
        if (sel) begin vs_b = vs; hr_b = hr; d_b = d; end
        else     begin vs_a = vs; hr_a = hr; d_a = d; end
    endtask

    task automatic vs_pulse(input logic sel);
        repeat (2) drv(sel, ~sel, 1'b0, 8'h00);
        repeat (2) drv(sel,  sel, 1'b0, 8'h00);
    endtask

    // Sends n bytes taken MSB-first from a left-aligned vector, then 4 idle.
    task automatic send_line(input logic sel, input logic [127:0] bytes,
                             input int n);
        for (int i = 0; i < n; i++) drv(sel, sel, 1'b1, bytes[127-8*i -: 8]);
        repeat (4) drv(sel, sel, 1'b0, 8'h00);
    endtask

    int          d0;
    logic [31:0] t34;
    int          exp_x[5] = '{0, 1, 2, 3, 3};

    initial begin
        rst = 1'b1;
        vs_a = 1'b0; hr_a = 1'b0; d_a = 8'h00;
        vs_b = 1'b1; hr_b = 1'b0; d_b = 8'h00;
`ifdef DVP_RX_STATS_EN
        a_ferr_seen = 1'b0;
        b_ferr_seen = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- 1: reset mid-line ----
        vs_pulse(1'b0);
        send_line(1'b0, {24'h010203, 104'h0}, 3);
        drv(1'b0, 1'b0, 1'b1, 8'h11);
        drv(1'b0, 1'b0, 1'b1, 8'h22);
        repeat (3) begin
            drv(1'b0, 1'b0, 1'b1, 8'h44);
            rst = 1'b1;
        end
        drv(1'b0, 1'b0, 1'b1, 8'h55);
        check_eq("rst data_o",   32'(a_do), 32'h0);
        check_eq("rst pix_y",    32'(a_y),  32'h0);
        check_eq("rst pix_x",    32'(a_x),  32'h0);
        check_eq("rst line_err", 32'(a_le), 32'h0);
        check_eq("rst href_o",   32'(a_hro), 32'h0);
        check_eq("rst strobes",  32'({a_dv, a_fs, a_fd, a_vso}), 32'h0);
        rst = 1'b0;
        qa.delete();
        repeat (4) drv(1'b0, 1'b0, 1'b1, 8'h66);
        repeat (4) drv(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("no valid before vsync", 32'(qa.size()), 32'd0);

        // ---- 2: two pixels, latency, alignment ----
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("vsync_o", 32'(a_vso), 32'h1);
        repeat (2) drv(1'b0, 1'b0, 1'b0, 8'h00);
        drv(1'b0, 1'b0, 1'b1, 8'h12);
        drv(1'b0, 1'b0, 1'b1, 8'h34);
        t34 = cyc;
        drv(1'b0, 1'b0, 1'b1, 8'hAB);
        drv(1'b0, 1'b0, 1'b1, 8'hCD);
        repeat (4) drv(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t2 count", 32'(qa.size()), 32'd2);
        if (qa.size() >= 2) begin
            check_eq("t2 px0 data",  32'(qa[0].d),  32'h1234);
            check_eq("t2 px0 xy",    32'({qa[0].x, qa[0].y}), 32'h0);
            check_eq("t2 px0 fs",    32'(qa[0].fs), 32'h1);
            check_eq("t2 px0 href",  32'(qa[0].hr), 32'h1);
            check_eq("t2 latency",   qa[0].cyc - t34, 32'd2);
            check_eq("t2 px1 data",  32'(qa[1].d),  32'hABCD);
            check_eq("t2 px1 x",     32'(qa[1].x),  32'd1);
            check_eq("t2 px1 y",     32'(qa[1].y),  32'd0);
            check_eq("t2 px1 fs",    32'(qa[1].fs), 32'h0);
        end
        check_eq("t2 data hold", 32'(a_do), 32'hABCD);
        check_eq("t2 pix_y end", 32'(a_y),  32'd1);
        check_eq("t2 pix_x end", 32'(a_x),  32'd0);

        // ---- 3: odd byte count ----
        qa.delete();
        d0 = na_done;
        vs_pulse(1'b0);
        check_eq("t3 frame_done once", 32'(na_done - d0), 32'd1);
`ifdef DVP_RX_STATS_EN
        check_eq("t3 frame_err a", 32'(a_ferr_seen), 32'h1);
`endif
        send_line(1'b0, {24'h556677, 104'h0}, 3);
        check_eq("t3 count", 32'(qa.size()), 32'd1);
        if (qa.size() >= 1) begin
            check_eq("t3 px data", 32'(qa[0].d), 32'h5566);
            check_eq("t3 px fs",   32'(qa[0].fs), 32'h1);
        end
        check_eq("t3 line_err", 32'(a_le), 32'h1);
        check_eq("t3 pix_y",    32'(a_y),  32'd1);
        vs_pulse(1'b0);
        check_eq("t3 line_err sticky", 32'(a_le), 32'h1);
        send_line(1'b0, {16'h9ABC, 112'h0}, 2);
        if (qa.size() >= 2) begin
            check_eq("t3 next fs", 32'(qa[1].fs), 32'h1);
            check_eq("t3 next le", 32'(qa[1].le), 32'h0);
        end
        check_eq("t3 line_err cleared", 32'(a_le), 32'h0);

        // ---- 4: x overflow with H_ACTIVE=4 ----
        qa.delete();
        vs_pulse(1'b0);
        send_line(1'b0, {80'h1011_2021_3031_4041_5051, 48'h0}, 10);
        check_eq("t4 count", 32'(qa.size()), 32'd5);
        if (qa.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check_eq($sformatf("t4 px%0d x", i), 32'(qa[i].x), 32'(exp_x[i]));
            check_eq("t4 px3 le",   32'(qa[3].le), 32'h0);
            check_eq("t4 px4 le",   32'(qa[4].le), 32'h1);
            check_eq("t4 px4 data", 32'(qa[4].d),  32'h5051);
        end
        check_eq("t4 line_err", 32'(a_le), 32'h1);
`ifdef DVP_RX_STATS_EN
        check_eq("t4 last_line_len", 32'(a_lll), 32'd5);
        check_eq("t4 line_cnt",      32'(a_lc),  32'd1);
`endif

        // ---- 5: active-low vsync, 2x2 frame ----
        check_eq("t5 b idle", 32'(qb.size()), 32'd0);
        vs_pulse(1'b1);
        send_line(1'b1, {32'hA1A2A3A4, 96'h0}, 4);
        send_line(1'b1, {32'hB1B2B3B4, 96'h0}, 4);
        d0 = nb_done;
        repeat (3) drv(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) drv(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("t5 frame_done once", 32'(nb_done - d0), 32'd1);
        check_eq("t5 count", 32'(qb.size()), 32'd4);
        if (qb.size() >= 4) begin
            check_eq("t5 px1 xy",   32'({qb[1].x, qb[1].y}), 32'({11'd1, 10'd0}));
            check_eq("t5 px2 xy",   32'({qb[2].x, qb[2].y}), 32'({11'd0, 10'd1}));
            check_eq("t5 px3 data", 32'(qb[3].d), 32'hB3B4);
            check_eq("t5 px3 y",    32'(qb[3].y), 32'd1);
        end
`ifdef DVP_RX_STATS_EN
        check_eq("t5 frame_err", 32'(b_ferr_seen), 32'h0);
`endif
        send_line(1'b1, {32'hC1C2C3C4, 96'h0}, 4);
        if (qb.size() >= 5) begin
            check_eq("t5 new frame y",  32'(qb[4].y),  32'd0);
            check_eq("t5 new frame fs", 32'(qb[4].fs), 32'h1);
        end

        // ---- 6: three lines against V_ACTIVE=2 ----
        send_line(1'b1, {32'hD1D2D3D4, 96'h0}, 4);
        send_line(1'b1, {32'hE1E2E3E4, 96'h0}, 4);
        check_eq("t6 pix_y", 32'(b_y), 32'd3);
`ifdef DVP_RX_STATS_EN
        check_eq("t6 line_cnt",      32'(b_lc),  32'd3);
        check_eq("t6 last_line_len", 32'(b_lll), 32'd2);
`endif
        d0 = nb_done;
        repeat (3) drv(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) drv(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("t6 frame_done", 32'(nb_done - d0), 32'd1);
`ifdef DVP_RX_STATS_EN
        check_eq("t6 frame_err", 32'(b_ferr_seen), 32'h1);
`endif
        d0 = nb_done;
        vs_pulse(1'b1);
        repeat (4) drv(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("empty frame no done", 32'(nb_done - d0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
